// File: rtl/key_repeat_pkg.sv
// Shared definitions for key_repeat: state encoding, default timing, accel threshold.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package key_repeat_pkg;

  // Tracker states; encodings are fixed so debug probes read consistently.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  // Defaults for the 100 MHz system clock: 167 ms DAS, 33 ms ARR.
  localparam int unsigned DAS_CYCLES_DEFAULT = 16_700_000;
  localparam int unsigned ARR_CYCLES_DEFAULT = 3_300_000;
  localparam int unsigned CNT_W_DEFAULT      = 25;

  // Number of repeat strobes in one hold before the interval halves (accel builds).
  localparam logic [3:0] ACCEL_THRESH = 4'd8;

endpackage

// File: rtl/key_repeat_if.sv
// Key event bundle between the debouncer side (master) and key_repeat (slave).
// Latency: n/a (wiring only).
// Backpressure: none; pulses and strobes are fire-and-forget.
interface key_repeat_if;

  logic press;   // one-cycle pulse, key went down
  logic rel;     // one-cycle pulse, key went up
  logic cancel;  // synchronous abort to idle
  logic fire;    // registered one-cycle move strobe
  logic held;    // registered level, key press being tracked

  modport master (
    output press,
    output rel,
    output cancel,
    input  fire,
    input  held
  );

  modport slave (
    input  press,
    input  rel,
    input  cancel,
    output fire,
    output held
  );

endinterface

// File: rtl/key_repeat.sv
// Delayed auto-shift: one strobe on press, then repeats every ARR after a DAS wait.
// Latency: press sampled at edge N -> fire high the cycle after edge N; all outputs registered.
// Backpressure: none; strobes are never stalled. Macro KEY_REPEAT_ACCEL_EN halves ARR after 8 repeats.
module key_repeat
  import key_repeat_pkg::*;
#(
  parameter int unsigned DAS_CYCLES = DAS_CYCLES_DEFAULT,
  parameter int unsigned ARR_CYCLES = ARR_CYCLES_DEFAULT,
  parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  key_repeat_if.slave  kif
);

  // Terminal counts are CNT_W-bit constants so the compare stays unsigned and width-exact.
  localparam logic [CNT_W-1:0] DAS_TC = CNT_W'(DAS_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARR_TC = CNT_W'(ARR_CYCLES - 1);

`ifdef KEY_REPEAT_ACCEL_EN
  // Fast interval is ARR/2, but never below 2 so fire cannot go high on back-to-back cycles.
  localparam int unsigned       ARR_FAST = ((ARR_CYCLES >> 1) < 2) ? 2 : (ARR_CYCLES >> 1);
  localparam logic [CNT_W-1:0]  FAST_TC  = CNT_W'(ARR_FAST - 1);
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             fire_q,  fire_d;
  logic             held_q,  held_d;
  logic [CNT_W-1:0] rep_tc;

`ifdef KEY_REPEAT_ACCEL_EN
  logic [3:0]       rep_q,   rep_d;

  // Repeat interval shortens once enough strobes have fired in this hold.
  assign rep_tc = (rep_q == ACCEL_THRESH) ? FAST_TC : ARR_TC;
`else
  assign rep_tc = ARR_TC;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Interval counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      fire_q <= 1'b0;
      held_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      fire_q <= fire_d;
      held_q <= held_d;
    end
  end

`ifdef KEY_REPEAT_ACCEL_EN
  // Saturating count of auto-repeat strobes within the current hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`endif

  // Next-state logic: cancel > release > press > counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire_d  = 1'b0;
    held_d  = held_q;
`ifdef KEY_REPEAT_ACCEL_EN
    rep_d   = rep_q;
`endif

    if (kif.cancel || kif.rel) begin
      // Release also beats a same-cycle press or a coinciding terminal count.
      state_d = ST_IDLE;
      cnt_d   = '0;
      held_d  = 1'b0;
`ifdef KEY_REPEAT_ACCEL_EN
      rep_d   = '0;
`endif
    end else if (kif.press) begin
      // Fresh press or re-press restarts DAS. If a strobe went out last cycle the new
      // one is swallowed, keeping fire from ever being high on two consecutive cycles.
      state_d = ST_DELAY;
      cnt_d   = '0;
      held_d  = 1'b1;
      fire_d  = ~fire_q;
`ifdef KEY_REPEAT_ACCEL_EN
      rep_d   = '0;
`endif
    end else begin
      unique case (state_q)
        ST_DELAY: begin
          if (cnt_q == DAS_TC) begin
            state_d = ST_REPEAT;
            cnt_d   = '0;
            fire_d  = 1'b1;
`ifdef KEY_REPEAT_ACCEL_EN
            if (rep_q != ACCEL_THRESH) rep_d = rep_q + 4'd1;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (cnt_q == rep_tc) begin
            cnt_d  = '0;
            fire_d = 1'b1;
`ifdef KEY_REPEAT_ACCEL_EN
            if (rep_q != ACCEL_THRESH) rep_d = rep_q + 4'd1;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          // IDLE, and recovery from the unused encoding.
          state_d = ST_IDLE;
          cnt_d   = '0;
          held_d  = 1'b0;
        end
      endcase
    end
  end

  // Outputs come straight from flops.
  always_comb begin
    kif.fire = fire_q;
    kif.held = held_q;
  end

endmodule
